// File: rtl/muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq : radix-2 sequential MIPS mult/multu/div/divu unit with HI/LO regs
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift, w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rmd;

  // op[0] == 0 selects the signed variants
  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -a : a;
  assign w_abs_b = w_b_neg ? -b : b;

  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in
  assign w_add      = acc_q[0] ? opb_q : '0;
  assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, w_add};
  assign w_mul_next = {w_sum, acc_q[WIDTH-1:1]};

  // Divide: dividend in acc low half shifts into the remainder, quotient bits shift in
  assign w_shift = {rem_q, acc_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, opb_q};
  assign w_qbit  = ~w_diff[WIDTH];

  assign w_prod = neg_res_q ? -acc_q : acc_q;
  assign w_quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rmd  = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!cancel) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, w_abs_a};
            rem_d     = '0;
            opb_d     = w_abs_b;
            is_div_d  = op[1];
            neg_res_d = w_a_neg ^ w_b_neg;
            neg_rem_d = w_a_neg;
            bzero_d   = (b == '0);
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_d = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], w_qbit};
          end else begin
            acc_d = w_mul_next;
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = w_prod[2*WIDTH-1:WIDTH];
            lo_d = w_prod[WIDTH-1:0];
          end else if (bzero_q) begin
            // A zero divisor leaves |a| in the remainder; re-signing restores a
            hi_d  = w_rmd;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = w_rmd;
            lo_d = w_quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// Bench for muldiv_seq: 32-bit and 8-bit instances, scoreboard of expected HI/LO.
module tb_muldiv_seq;

  typedef longint unsigned u64_t;
  typedef struct {
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cancel, hi_we, lo_we;
  logic [31:0] wdata;
  logic        start32, start8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, dbz32, busy8, done8, dbz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata[7:0]),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  // Reference arithmetic on 64-bit integers
  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    u64_t   m, ua, ub, pu;
    longint sa, sbv, q, r;
    m  = (u64_t'(1) << w) - u64_t'(1);
    ua = u64_t'(a) & m;
    ub = u64_t'(b) & m;
    sa  = ua[w-1] ? ($signed(ua) - (longint'(1) << w)) : $signed(ua);
    sbv = ub[w-1] ? ($signed(ub) - (longint'(1) << w)) : $signed(ub);
    e.dbz = 1'b0;
    pu = 0;
    case (op)
      2'd0: pu = u64_t'(sa * sbv);
      2'd1: pu = ua * ub;
      default: begin
        if (ub == 0) begin
          e.dbz = 1'b1;
          pu = (ua << w) | m;
        end else if (op == 2'd2) begin
          q  = sa / sbv;
          r  = sa % sbv;
          pu = ((u64_t'(r) & m) << w) | (u64_t'(q) & m);
        end else begin
          pu = ((ua % ub) << w) | (ua / ub);
        end
      end
    endcase
    e.hi = 32'((pu >> w) & m);
    e.lo = 32'(pu & m);
    return e;
  endfunction

  function automatic logic get_busy(input bit w8); return w8 ? busy8 : busy32; endfunction
  function automatic logic get_done(input bit w8); return w8 ? done8 : done32; endfunction
  function automatic logic get_dbz(input bit w8);  return w8 ? dbz8 : dbz32;   endfunction
  function automatic logic [31:0] get_hi(input bit w8); return w8 ? {24'd0, hi8} : hi32; endfunction
  function automatic logic [31:0] get_lo(input bit w8); return w8 ? {24'd0, lo8} : lo32; endfunction

  task automatic set_start(input bit w8, input logic v);
    if (w8) start8 = v; else start32 = v;
  endtask

  // Start pulse sampled at the posedge between two negedges; operands scrambled afterwards
  task automatic drive_start(input bit w8, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    @(negedge clk);
    if (w8) begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin op32 = op; a32 = a; b32 = b; end
    set_start(w8, 1'b1);
    @(negedge clk);
    set_start(w8, 1'b0);
    a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    op32 = 2'($urandom); op8 = 2'($urandom);
  endtask

  task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit pulse_chk, input bit inject);
    int   w, n, bcnt;
    bit   got;
    exp_t e;
    w = w8 ? 8 : 32;
    sbq.push_back(model(w, op, a, b));
    drive_start(w8, op, a, b);
    bcnt = get_busy(w8) ? 1 : 0;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 3) begin
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; set_start(w8, 1'b1);
      end
      if (inject && n == 4) begin
        hi_we = 1'b0; lo_we = 1'b0; set_start(w8, 1'b0);
      end
      if (get_done(w8)) got = 1;
      else if (get_busy(w8)) bcnt++;
    end
    e = sbq.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d edges, required at %0d", n, w + 1);
      return;
    end
    n_checks++;
    if (n !== w + 1) begin
      n_fail++; $display("FAIL latency: got %0d edges, required %0d", n, w + 1);
    end
    n_checks++;
    if (bcnt !== w + 1) begin
      n_fail++; $display("FAIL busy_cycles: got %0d, required %0d", bcnt, w + 1);
    end
    n_checks++;
    if (get_hi(w8) !== e.hi) begin
      n_fail++; $display("FAIL hi op=%0d a=%h b=%h: got %h, required %h", op, a, b, get_hi(w8), e.hi);
    end
    n_checks++;
    if (get_lo(w8) !== e.lo) begin
      n_fail++; $display("FAIL lo op=%0d a=%h b=%h: got %h, required %h", op, a, b, get_lo(w8), e.lo);
    end
    n_checks++;
    if (get_dbz(w8) !== e.dbz) begin
      n_fail++; $display("FAIL div_by_zero op=%0d b=%h: got %b, required %b", op, b, get_dbz(w8), e.dbz);
    end
    if (pulse_chk) begin
      @(posedge clk); #1;
      n_checks++;
      if (get_done(w8) !== 1'b0 || get_dbz(w8) !== 1'b0) begin
        n_fail++; $display("FAIL done_pulse: done/dbz still %b/%b, required 0/0", get_done(w8), get_dbz(w8));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cancel = 0; hi_we = 0; lo_we = 0; wdata = '0;
    start32 = 0; start8 = 0; op32 = 0; op8 = 0; a32 = 0; b32 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy32, done32, dbz32} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl32: got %b, required 000", {busy32, done32, dbz32});
    end
    n_checks++;
    if ({hi32, lo32} !== 64'd0) begin
      n_fail++; $display("FAIL reset_hilo32: got %h, required 0", {hi32, lo32});
    end
    n_checks++;
    if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
      n_fail++; $display("FAIL reset8: got %h, required 0", {busy8, done8, dbz8, hi8, lo8});
    end
  endtask

  task automatic test_mthi();
    @(negedge clk); hi_we = 1; wdata = 32'h1111_1111;
    @(negedge clk); hi_we = 0;
    n_checks++;
    if (hi32 !== 32'h1111_1111 || lo32 !== 32'd0 || hi8 !== 8'h11) begin
      n_fail++; $display("FAIL mthi: got hi=%h lo=%h hi8=%h, required 11111111/0/11", hi32, lo32, hi8);
    end
    @(negedge clk); hi_we = 1; lo_we = 1; wdata = 32'hA5A5_A5A5;
    @(negedge clk); hi_we = 0; lo_we = 0;
    n_checks++;
    if (hi32 !== 32'hA5A5_A5A5 || lo32 !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL mthi_mtlo: got hi=%h lo=%h, required a5a5a5a5 both", hi32, lo32);
    end
    @(negedge clk); lo_we = 1; wdata = 32'h2222_2222;
    @(negedge clk); lo_we = 0;
    n_checks++;
    if (hi32 !== 32'hA5A5_A5A5 || lo32 !== 32'h2222_2222) begin
      n_fail++; $display("FAIL mtlo: got hi=%h lo=%h, required a5a5a5a5/22222222", hi32, lo32);
    end
  endtask

  task automatic test_mult();
    run_op(0, 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1, 0);
    run_op(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run_op(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run_op(0, 2'd0, 32'h8000_0000, 32'h8000_0000, 1, 0);
    for (int i = 0; i < 4; i++) run_op(0, {1'b0, 1'($urandom)}, $urandom, $urandom, 1, 0);
  endtask

  task automatic test_div();
    run_op(0, 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1, 0);
    run_op(0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run_op(0, 2'd3, 32'h0000_0064, 32'h0000_0007, 1, 0);
    run_op(0, 2'd3, 32'h0000_0064, 32'h0000_0000, 1, 0);
    run_op(0, 2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1, 0);
    run_op(0, 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1, 0);
    for (int i = 0; i < 4; i++) run_op(0, {1'b1, 1'($urandom)}, $urandom, $urandom, 1, 0);
  endtask

  task automatic test_back_to_back();
    run_op(0, 2'd1, 32'h0001_0003, 32'h0002_0005, 0, 0);
    run_op(0, 2'd3, 32'hFFFF_0000, 32'h0000_0101, 0, 0);
    run_op(0, 2'd2, 32'h8000_0001, 32'h0000_0003, 1, 0);
  endtask

  task automatic test_busy_ignore();
    run_op(0, 2'd0, 32'd5, 32'd6, 1, 1);
  endtask

  task automatic test_cancel();
    logic [31:0] hold_lo;
    bit          seen;
    @(negedge clk); hi_we = 1; wdata = 32'h1111_1111;
    @(negedge clk); hi_we = 0;
    hold_lo = lo32;
    drive_start(0, 2'd0, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++;
    if (busy32 !== 1'b0) begin
      n_fail++; $display("FAIL cancel_calc_busy: got %b, required 0", busy32);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done32) seen = 1; end
    n_checks++;
    if (seen || hi32 !== 32'h1111_1111 || lo32 !== hold_lo) begin
      n_fail++; $display("FAIL cancel_calc_hilo: done=%b hi=%h lo=%h, required 0/11111111/%h", seen, hi32, lo32, hold_lo);
    end
    // cancel arriving while in FIX suppresses the write
    drive_start(0, 2'd1, 32'd3, 32'd4);
    repeat (32) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b0 || hi32 !== 32'h1111_1111 || lo32 !== hold_lo) begin
      n_fail++; $display("FAIL cancel_fix: done=%b busy=%b hi=%h lo=%h, required 0/0/11111111/%h", done32, busy32, hi32, lo32, hold_lo);
    end
    @(negedge clk); start32 = 1; cancel = 1; op32 = 2'd0;
    @(negedge clk); start32 = 0; cancel = 0;
    n_checks++;
    if (busy32 !== 1'b0) begin
      n_fail++; $display("FAIL start_with_cancel: busy got %b, required 0", busy32);
    end
    @(negedge clk); start32 = 1; op32 = 2'd3; a32 = 32'd9; b32 = 32'd2; hi_we = 1; wdata = 32'hCAFE_F00D;
    @(negedge clk); start32 = 0; hi_we = 0;
    n_checks++;
    if (busy32 !== 1'b1 || hi32 !== 32'h1111_1111) begin
      n_fail++; $display("FAIL start_beats_mthi: busy=%b hi=%h, required 1/11111111", busy32, hi32);
    end
    #1 cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_start(0, 2'd0, 32'hFFFF_FFFD, 32'd7);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy32, done32, dbz32} !== 3'b000 || {hi32, lo32} !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all 0", busy32, done32, hi32, lo32);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(0, 2'd2, 32'd100, 32'hFFFF_FFF9, 1, 0);
  endtask

  task automatic test_width8();
    run_op(1, 2'd0, 32'hFD, 32'h07, 1, 0);
    run_op(1, 2'd1, 32'hFF, 32'hFF, 1, 0);
    run_op(1, 2'd0, 32'hFF, 32'hFF, 1, 0);
    run_op(1, 2'd2, 32'hF9, 32'h02, 1, 0);
    run_op(1, 2'd2, 32'h80, 32'hFF, 1, 0);
    run_op(1, 2'd3, 32'h64, 32'h07, 1, 0);
    run_op(1, 2'd3, 32'h64, 32'h00, 1, 0);
    for (int i = 0; i < 6; i++) run_op(1, 2'($urandom), $urandom, $urandom, 1, 0);
  endtask

  initial begin
    test_reset();
    test_mthi();
    test_mult();
    test_div();
    test_back_to_back();
    test_busy_ignore();
    test_cancel();
    test_reset_mid();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
